// File: rtl/light_pkg.sv
// Shared luminosity levels, default colour names and the ramp step helper
// used by the multi-zone light controller.
package light_pkg;

    typedef enum logic [1:0] {
        LIGHTS_OFF        = 2'd0,
        LOW_LUMINOSITY    = 2'd1,
        MEDIUM_LUMINOSITY = 2'd2,
        HIGH_LUMINOSITY   = 2'd3
    } lum_level_e;

    typedef enum logic [1:0] {
        NATURAL = 2'd0,
        WHITE   = 2'd1,
        BLUE    = 2'd2,
        ORANGE  = 2'd3
    } color4_e;

    // One luminosity step from cur toward tgt, never past it.
    function automatic logic [1:0] step_toward(input logic [1:0] cur, input logic [1:0] tgt);
        logic [1:0] nxt;
        if (cur < tgt) begin
            nxt = cur + 2'd1;
        end else if (cur > tgt) begin
            nxt = cur - 2'd1;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/light_zone.sv
// One lighting zone: button synchroniser and debounce, colour counter,
// sensor-to-target mapping with hysteresis, and the luminosity ramp.
module light_zone
    import light_pkg::*;
#(
    parameter int SENSOR_W        = 8,
    parameter int NUM_COLORS      = 4,
    parameter int COLOR_W         = 2,
    parameter int T1              = 15,
    parameter int T2              = 30,
    parameter int T3              = 50,
    parameter int HYST            = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_i,
    input  logic                button_i,
    input  logic [SENSOR_W-1:0] sensor_i,
    input  logic                all_off_i,
    output logic [1:0]          lum_o,
    output logic [COLOR_W-1:0]  color_o,
    output logic                ramping_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [COLOR_W-1:0]  COLOR_LAST = COLOR_W'(NUM_COLORS - 1);
    localparam logic [SENSOR_W:0]   T1_W       = (SENSOR_W + 1)'(T1);
    localparam logic [SENSOR_W:0]   T2_W       = (SENSOR_W + 1)'(T2);
    localparam logic [SENSOR_W:0]   T3_W       = (SENSOR_W + 1)'(T3);
    localparam logic [SENSOR_W:0]   HYST_W     = (SENSOR_W + 1)'(HYST);
    localparam logic [SENSOR_W:0]   SMAX_W     = {1'b0, {SENSOR_W{1'b1}}};

    function automatic logic [1:0] band_level(input logic [SENSOR_W:0] s);
        logic [1:0] lvl;
        if (s < T1_W) begin
            lvl = HIGH_LUMINOSITY;
        end else if (s < T2_W) begin
            lvl = MEDIUM_LUMINOSITY;
        end else if (s < T3_W) begin
            lvl = LOW_LUMINOSITY;
        end else begin
            lvl = LIGHTS_OFF;
        end
        return lvl;
    endfunction

    logic               sync1_q, sync1_d, sync2_q, sync2_d, stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic [1:0]         target_q, target_d, lum_q, lum_d;
    logic               press_s;
    logic [SENSOR_W:0]  s_ext_s, sum_s, sp_s, sm_s;
    logic [1:0]         lvl_up_s, lvl_dn_s;

    // Next-state logic for debounce, colour, target and ramp.
    always_comb begin
        sync1_d  = button_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_s  = 1'b0;
        color_d  = color_q;
        target_d = target_q;
        lum_d    = lum_q;

        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            press_s  = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (press_s) begin
            color_d = (color_q == COLOR_LAST) ? '0 : color_q + 1'b1;
        end else begin
            color_d = color_q;
        end

        // Widened by one bit so the saturating add cannot wrap.
        s_ext_s  = {1'b0, sensor_i};
        sum_s    = s_ext_s + HYST_W;
        sp_s     = (sum_s > SMAX_W) ? SMAX_W : sum_s;
        sm_s     = (s_ext_s >= HYST_W) ? (s_ext_s - HYST_W) : '0;
        lvl_up_s = band_level(sp_s);
        lvl_dn_s = band_level(sm_s);

        if (all_off_i) begin
            target_d = LIGHTS_OFF;
        end else if (lvl_up_s > target_q) begin
            target_d = lvl_up_s;
        end else if (lvl_dn_s < target_q) begin
            target_d = lvl_dn_s;
        end else begin
            target_d = target_q;
        end

        if (tick_i) begin
            lum_d = step_toward(lum_q, target_q);
        end else begin
            lum_d = lum_q;
        end
    end

    // Zone state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            color_q  <= '0;
            target_q <= LIGHTS_OFF;
            lum_q    <= LIGHTS_OFF;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            color_q  <= color_d;
            target_q <= target_d;
            lum_q    <= lum_d;
        end
    end

    assign lum_o     = lum_q;
    assign color_o   = color_q;
    assign ramping_o = (lum_q != target_q);

endmodule

// File: rtl/light_zone_ctrl.sv
// Multi-zone light controller: shared ramp prescaler plus one light_zone
// per zone, with per-zone fields packed into flat buses.
module light_zone_ctrl
    import light_pkg::*;
#(
    parameter int NUM_ZONES       = 2,
    parameter int SENSOR_W        = 8,
    parameter int NUM_COLORS      = 4,
    parameter int T1              = 15,
    parameter int T2              = 30,
    parameter int T3              = 50,
    parameter int HYST            = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RAMP_DIV        = 4,
    localparam int COLOR_W        = (NUM_COLORS < 2) ? 1 : $clog2(NUM_COLORS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_ZONES-1:0]            color_button,
    input  logic [NUM_ZONES*SENSOR_W-1:0]   sunlight_sensor,
    input  logic                            all_off,
    output logic [NUM_ZONES*2-1:0]          luminosity,
    output logic [NUM_ZONES*COLOR_W-1:0]    color,
    output logic [NUM_ZONES-1:0]            ramping
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_s;

    // Prescaler wrap and ramp tick generation.
    always_comb begin
        tick_s = (pre_q == PRE_LAST);
        if (tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar z = 0; z < NUM_ZONES; z++) begin : g_zone
        light_zone #(
            .SENSOR_W        (SENSOR_W),
            .NUM_COLORS      (NUM_COLORS),
            .COLOR_W         (COLOR_W),
            .T1              (T1),
            .T2              (T2),
            .T3              (T3),
            .HYST            (HYST),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_zone (
            .clk       (clk),
            .rst_n     (reset),
            .tick_i    (tick_s),
            .button_i  (color_button[z]),
            .sensor_i  (sunlight_sensor[z*SENSOR_W +: SENSOR_W]),
            .all_off_i (all_off),
            .lum_o     (luminosity[2*z +: 2]),
            .color_o   (color[z*COLOR_W +: COLOR_W]),
            .ramping_o (ramping[z])
        );
    end

endmodule
